// File: rtl/kgp_pkg.sv
// kgp_pkg
// Shared definitions for the KGP-RISC datapath blocks.
//   MODE_FIXED / MODE_RR : arbitration mode encodings for the mode input
//   clog2()              : ceiling log2, usable in parameter expressions
package kgp_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Smallest r with 2**r >= value; callers guarantee value >= 2.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational arbiter: fixed priority (lowest index wins) or round-robin
// starting at ptr and scanning upward modulo N.
// Ports:
//   mode        : MODE_FIXED or MODE_RR
//   req         : per-channel request vector
//   ptr         : round-robin start index, always < N
//   grant       : one-hot grant, zero when nothing requests
//   grant_idx   : encoded index of the granted channel
//   grant_valid : some channel was granted
module rr_arbiter
   import kgp_pkg::*;
#(
   parameter  int N    = 4,
   localparam int SELW = clog2(N)
) (
   input  logic            mode,
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] grant_idx,
   output logic            grant_valid
);

   // Walk the channels in priority order; the first requester wins. In
   // round-robin mode the walk starts at ptr and wraps at N, so indices
   // at or above N are never visited.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         int pos;
         pos = (mode == MODE_RR) ? int'(ptr) + k : k;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!grant_valid && req[pos]) begin
            grant[pos]  = 1'b1;
            grant_idx   = SELW'(pos);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux_n1.sv
// arb_mux_n1
// Registered N:1 arbitrating multiplexer with valid/ready on every channel
// and a one-entry output register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   mode       : 0 = fixed priority, 1 = round-robin
//   in_valid   : per-channel request
//   in_data    : channel i in bits [i*WIDTH +: WIDTH]
//   in_ready   : one-hot accept, zero when stalled or in reset
//   out_valid  : output register holds a word
//   out_data   : data of the granted channel
//   out_sel    : index of the channel that produced out_data
//   out_ready  : consumer takes the word this cycle
module arb_mux_n1
   import kgp_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SELW  = clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   input  logic               out_ready
);

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] ptr_next;
   logic [N-1:0]    grant;
   logic [SELW-1:0] grant_idx;
   logic            grant_valid;
   logic            load;
   logic            transfer;

   rr_arbiter #(.N(N)) u_arbiter (
      .mode        (mode),
      .req         (in_valid),
      .ptr         (ptr),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // The register can take a new word when it is empty or being drained
   // this same cycle, which gives back-to-back transfers with no bubble.
   // Nothing is accepted while reset is asserted.
   always_comb begin
      load     = !out_valid || out_ready;
      in_ready = (load && !rst) ? grant : '0;
      transfer = grant_valid && load && !rst;
      ptr_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
   end

   // Output register and round-robin pointer. The pointer advances on
   // every transfer regardless of mode so a switch to round-robin resumes
   // just after the last granted channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_sel   <= grant_idx;
            ptr       <= ptr_next;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_n1.sv
// tb_arb_mux_n1
// Randomized and directed bench for arb_mux_n1 (N=4, WIDTH=32) with a
// scoreboard: accepted words are queued by the stimulus side and popped
// by an independent monitor when the consumer takes them.
module tb_arb_mux_n1;

   localparam int N     = 4;
   localparam int WIDTH = 32;
   localparam int SELW  = 2;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               sel;
   } word_t;

   logic               clk;
   logic               rst;
   logic               mode;
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_sel;
   logic               out_ready;

   // Reference model state
   word_t            sb_q[$];
   int               m_ptr;
   bit               m_full;
   logic [WIDTH-1:0] m_data;
   int               m_sel;

   int checks;
   int passes;

   arb_mux_n1 #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Winner under the arbitration rules: lowest requester, or first
   // requester found counting up from p and wrapping at N.
   function automatic int refGrant(input bit md, input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = md ? (p + k) % N : k;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic checkEq(input string name, input logic [WIDTH-1:0] act,
                          input logic [WIDTH-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic checkOutput(input logic [N-1:0] exp_ready);
      checkEq("in_ready", WIDTH'(in_ready), WIDTH'(exp_ready));
      checkEq("out_valid", WIDTH'(out_valid), WIDTH'(m_full));
      checkEq("out_data", out_data, m_data);
      checkEq("out_sel", WIDTH'(out_sel), WIDTH'(m_sel));
   endtask

   // One cycle: drive at negedge, check just after, update model after
   // the rising edge that commits the cycle.
   task automatic applyStimulus(input bit r, input bit md, input logic [N-1:0] v,
                                input logic [N*WIDTH-1:0] d, input bit ordy,
                                output int g);
      bit               ld;
      logic [N-1:0]     exp_ready;
      word_t            w;
      @(negedge clk);
      rst       = r;
      mode      = md;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      ld = !m_full || ordy;
      g  = (r || !ld) ? -1 : refGrant(md, v, m_ptr);
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      checkOutput(exp_ready);
      @(posedge clk);
      #1;
      if (r) begin
         sb_q.delete();
         m_ptr  = 0;
         m_full = 0;
         m_data = '0;
         m_sel  = 0;
      end else if (ld) begin
         if (g >= 0) begin
            w.data = d[g*WIDTH +: WIDTH];
            w.sel  = g;
            sb_q.push_back(w);
            m_full = 1;
            m_data = w.data;
            m_sel  = g;
            m_ptr  = (g + 1) % N;
         end else begin
            m_full = 0;
         end
      end
   endtask

   // Monitor: whenever the consumer takes a word, it must be the oldest
   // word the model expects.
   initial begin
      word_t w;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               $display("[TB] FAIL monitor_pop: got word %0h with empty scoreboard", out_data);
            end else begin
               w = sb_q.pop_front();
               if (out_data === w.data && int'(out_sel) == w.sel) passes++;
               else $display("[TB] FAIL monitor_word: got %0h/%0d expected %0h/%0d",
                             out_data, out_sel, w.data, w.sel);
            end
         end
      end
   end

   function automatic logic [N*WIDTH-1:0] pack4(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                                input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   initial begin
      int               g;
      bit               pend[N];
      logic [WIDTH-1:0] pdata[N];
      logic [N*WIDTH-1:0] dd;
      logic [N-1:0]     vv;
      bit               md;

      checks = 0;
      passes = 0;
      m_ptr  = 0;
      m_full = 0;
      m_data = '0;
      m_sel  = 0;
      rst = 1'b1; mode = 1'b0; in_valid = '1; out_ready = 1'b1;
      in_data = pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      for (int i = 0; i < N; i++) begin
         pend[i]  = 0;
         pdata[i] = '0;
      end

      // Reset with every channel requesting, then first grant
      dd = pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      applyStimulus(1, 0, 4'b1111, dd, 1, g);
      applyStimulus(1, 0, 4'b1111, dd, 1, g);
      applyStimulus(0, 0, 4'b1111, dd, 1, g);

      // Fixed priority: ch1 starves ch3
      dd = pack4(32'h0, 32'h11, 32'h0, 32'h33);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 4'b1010, dd, 1, g);

      // Round-robin over all channels
      dd = pack4(32'hC0, 32'hC1, 32'hC2, 32'hC3);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 4'b1111, dd, 1, g);
      applyStimulus(0, 1, 4'b0000, dd, 1, g);

      // Backpressure: hold 0xAA while ch2 waits
      dd = pack4(32'hAA, 32'h0, 32'h22, 32'h0);
      applyStimulus(0, 0, 4'b0001, dd, 1, g);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'b0100, dd, 0, g);
      applyStimulus(0, 0, 4'b0100, dd, 1, g);
      applyStimulus(0, 0, 4'b0000, dd, 1, g);
      applyStimulus(0, 0, 4'b0000, dd, 1, g);

      // Wrap and skip: reach ptr=3 via ch2, then 0101 -> ch0 then ch2
      dd = pack4(32'hD0, 32'hD1, 32'hD2, 32'hD3);
      applyStimulus(0, 1, 4'b0100, dd, 1, g);
      applyStimulus(0, 1, 4'b0101, dd, 1, g);
      applyStimulus(0, 1, 4'b0101, dd, 1, g);
      applyStimulus(0, 1, 4'b0000, dd, 1, g);

      // Mid-stream reset with a word held and ch1 requesting
      dd = pack4(32'hE0, 32'hE1, 32'hE2, 32'hE3);
      applyStimulus(0, 1, 4'b0010, dd, 0, g);
      applyStimulus(1, 1, 4'b0010, dd, 1, g);
      applyStimulus(0, 1, 4'b1111, dd, 1, g);
      applyStimulus(0, 1, 4'b0000, dd, 1, g);

      // Randomized traffic with producers holding until accepted
      md = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]  = 1;
               pdata[i] = $urandom;
            end
            vv[i] = pend[i];
            dd[i*WIDTH +: WIDTH] = pdata[i];
         end
         if ($urandom_range(0, 15) == 0) md = ~md;
         applyStimulus(($urandom_range(0, 63) == 0), md, vv, dd,
                       ($urandom_range(0, 3) != 0), g);
         if (g >= 0) pend[g] = 0;
      end

      // Drain and confirm nothing is left outstanding
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'b0000, dd, 1, g);
      checkEq("scoreboard_empty", WIDTH'(sb_q.size()), '0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
